soc_bus_arbiter: RTL and testbench

SOC_BUS_ARBITER -- requirements
Module: soc_bus_arbiter

---
 rtl/soc_bus_arbiter.sv | 157 +++++++++++++++
 tb/tb_soc_bus_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/soc_bus_arbiter.sv
// soc_bus_arbiter: round-robin arbiter for N bus masters sharing one slave.
// The owner keeps the bus until it drops its request. A watchdog forcibly
// releases an owner that sees no ack for TIMEOUT cycles; a one-cycle gap
// follows, and the released master then has lowest priority.
module soc_bus_arbiter #(
    parameter int N       = 2,
    parameter int TW      = 8,
    parameter int TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         ack,
    output logic [N-1:0] gnt,
    output logic         busy,
    output logic         tout
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_OWN,
        S_BACKOFF
    } state_e;

    // The watchdog fires when the count reaches this value with ack still low.
    localparam logic [TW-1:0] CNT_LAST = TW'(TIMEOUT - 1);
    // Reset value of the last owner: master N-1, so master 0 wins first.
    localparam logic [N-1:0]  LAST_RST = {1'b1, {(N-1){1'b0}}};

    state_e        state_q, state_d;
    logic [N-1:0]  gnt_q,   gnt_d;
    logic [N-1:0]  last_q,  last_d;
    logic [TW-1:0] cnt_q,   cnt_d;
    logic          busy_q,  busy_d;
    logic          tout_q,  tout_d;

    logic [N-1:0]  pick;
    logic          owner_req;

    // Round-robin pick: first requester above the last owner, wrapping;
    // the last owner itself is considered last.
    function automatic logic [N-1:0] rr_pick(input logic [N-1:0] r,
                                             input logic [N-1:0] l);
        logic [N-1:0] res;
        logic         found;
        int           lidx;
        int           idx;
        res   = '0;
        found = 1'b0;
        lidx  = 0;
        for (int i = 0; i < N; i++) begin
            if (l[i]) lidx = i;
        end
        for (int k = 1; k <= N; k++) begin
            idx = (lidx + k) % N;
            if (!found && r[idx]) begin
                res[idx] = 1'b1;
                found    = 1'b1;
            end
        end
        return res;
    endfunction

    // While in OWN, last_q is the current owner, so the same rotation serves
    // both a fresh arbitration and a hand-off to the remaining requesters.
    assign pick      = rr_pick(req, last_q);
    assign owner_req = |(req & gnt_q);

    // Next-state, grant and watchdog logic.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        tout_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (|req) begin
                    gnt_d   = pick;
                    last_d  = pick;
                    state_d = S_OWN;
                end else begin
                    gnt_d = '0;
                end
            end

            S_OWN: begin
                if (!owner_req) begin
                    // Owner released: hand over in the same edge, no dead cycle.
                    cnt_d = '0;
                    if (|req) begin
                        gnt_d  = pick;
                        last_d = pick;
                    end else begin
                        gnt_d   = '0;
                        state_d = S_IDLE;
                    end
                end else if (ack) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    // Forced release; last_q keeps the old owner so it loses
                    // the next arbitration.
                    gnt_d   = '0;
                    tout_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = S_BACKOFF;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + TW'(1);
                end
            end

            S_BACKOFF: begin
                gnt_d   = '0;
                cnt_d   = '0;
                state_d = S_IDLE;
            end

            default: begin
                gnt_d   = '0;
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase

        busy_d = |gnt_d;
    end

    // State register with synchronous active-high reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register updating from the
        // values present before the edge, independent of statement order.
        if (rst) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            last_q  <= LAST_RST;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            tout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            tout_q  <= tout_d;
        end
    end

    assign gnt  = gnt_q;
    assign busy = busy_q;
    assign tout = tout_q;

endmodule

// File: tb/tb_soc_bus_arbiter.sv
// Testbench for soc_bus_arbiter (N=4, TIMEOUT=4): directed scenarios with
// literal expectations plus a random phase, all compared every cycle against
// an integer-level behavioural model.
module tb_soc_bus_arbiter;

    localparam int N       = 4;
    localparam int TW      = 8;
    localparam int TIMEOUT = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] req = '0;
    logic         ack = 1'b0;
    logic [N-1:0] gnt;
    logic         busy;
    logic         tout;

    int checks = 0;
    int errors = 0;

    soc_bus_arbiter #(.N(N), .TW(TW), .TIMEOUT(TIMEOUT)) dut (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .ack  (ack),
        .gnt  (gnt),
        .busy (busy),
        .tout (tout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: owner index (-1 = none), last owner index,
    // watchdog count, pending one-cycle gap after a timeout, tout pulse.
    typedef struct packed {
        int   owner;
        int   last;
        int   wd;
        logic gap;
        logic tout;
    } model_t;

    model_t       m = '{owner: -1, last: N-1, wd: 0, gap: 1'b0, tout: 1'b0};
    logic         m_valid   = 1'b0;
    logic [N-1:0] m_req_sel = '0;
    logic         m_rst_sel = 1'b0;

    function automatic int rr(input logic [N-1:0] r, input int l);
        for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (l + k) % N;
            if (r[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic model_t next_model(input model_t c, input logic [N-1:0] r,
                                          input logic a, input logic rs);
        model_t n;
        n      = c;
        n.tout = 1'b0;
        if (rs) begin
            n.owner = -1; n.last = N-1; n.wd = 0; n.gap = 1'b0;
        end else if (c.gap) begin
            n.gap   = 1'b0;
            n.owner = -1;
        end else if (c.owner < 0) begin
            if (r != '0) begin
                n.owner = rr(r, c.last);
                n.last  = n.owner;
                n.wd    = 0;
            end
        end else if (!r[c.owner]) begin
            n.owner = rr(r, c.last);
            if (n.owner >= 0) n.last = n.owner;
            n.wd = 0;
        end else if (a) begin
            n.wd = 0;
        end else if (c.wd == TIMEOUT - 1) begin
            n.owner = -1; n.tout = 1'b1; n.gap = 1'b1; n.wd = 0;
        end else begin
            n.wd = c.wd + 1;
        end
        return n;
    endfunction

    function automatic logic [N-1:0] model_gnt(input model_t c);
        logic [N-1:0] g;
        g = '0;
        if (c.owner >= 0) g[c.owner] = 1'b1;
        return g;
    endfunction

    // Model advances on the same edge as the DUT, from the same inputs.
    always @(posedge clk) begin
        m         <= next_model(m, req, ack, rst);
        m_req_sel <= req;
        m_rst_sel <= rst;
        if (rst) m_valid <= 1'b1;
    end

    // Compare process: DUT outputs against the model on every falling edge,
    // plus grant sanity and fairness (at most N-1 other ownerships while a
    // master keeps requesting).
    logic [N-1:0] prev_gnt = '0;
    int           waits [N];

    initial begin
        for (int i = 0; i < N; i++) waits[i] = 0;
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("gnt",  32'(gnt),  32'(model_gnt(m)));
            check("busy", 32'(busy), 32'(m.owner >= 0));
            check("tout", 32'(tout), 32'(m.tout));
            check("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
            if (gnt != '0) check("gnt_to_requester", 32'(|(gnt & m_req_sel)), 32'd1);
            for (int i = 0; i < N; i++) begin
                if (m_rst_sel || gnt[i] || !m_req_sel[i]) begin
                    waits[i] <= 0;
                end else if (gnt != '0 && gnt != prev_gnt) begin
                    waits[i] <= waits[i] + 1;
                    check("fairness", 32'(waits[i] + 1 > N - 1), 32'd0);
                end
            end
            prev_gnt <= gnt;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [N-1:0] rreq;

        rst = 1'b1; req = '0; ack = 1'b0;
        tick();
        tick();
        check("rst_gnt",  32'(gnt),  32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_tout", 32'(tout), 32'h0);

        // First arbitration after reset: master 0 wins.
        rst = 1'b0; req = 4'b1111;
        tick();
        check("first_gnt",  32'(gnt),  32'b0001);
        check("first_busy", 32'(busy), 32'h1);

        // Hand-off with no dead cycle, rotating upward and wrapping.
        req = 4'b1110; tick(); check("handoff_1", 32'(gnt), 32'b0010);
        req = 4'b1100; tick(); check("handoff_2", 32'(gnt), 32'b0100);
        req = 4'b1000; tick(); check("handoff_3", 32'(gnt), 32'b1000);
        req = 4'b0001; tick(); check("handoff_0", 32'(gnt), 32'b0001);
        req = 4'b0000; tick();
        check("release_gnt",  32'(gnt),  32'h0);
        check("release_busy", 32'(busy), 32'h0);

        // Timeout of owner 2, one gap cycle, then master 0 has priority.
        req = 4'b0100; tick();
        check("to_grant", 32'(gnt), 32'b0100);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("to_hold_gnt",  32'(gnt),  32'b0100);
            check("to_hold_tout", 32'(tout), 32'h0);
        end
        tick();
        check("to_gnt",  32'(gnt),  32'h0);
        check("to_tout", 32'(tout), 32'h1);
        req = 4'b0101; tick();
        check("backoff_gnt",  32'(gnt),  32'h0);
        check("backoff_tout", 32'(tout), 32'h0);
        tick();
        check("after_backoff_gnt", 32'(gnt), 32'b0001);

        // Periodic ack keeps the watchdog from firing; no preemption by 2.
        for (int i = 0; i < 50; i++) begin
            ack = (i % 3 == 2);
            tick();
            check("ack_hold_gnt",  32'(gnt),  32'b0001);
            check("ack_hold_tout", 32'(tout), 32'h0);
        end
        ack = 1'b0;

        // Owner 0 drops; master 2 takes over.
        req = 4'b0100; tick();
        check("to2_gnt", 32'(gnt), 32'b0100);

        // ack in the timeout cycle wins.
        repeat (3) tick();
        ack = 1'b1; tick();
        check("ack_wins_gnt",  32'(gnt),  32'b0100);
        check("ack_wins_tout", 32'(tout), 32'h0);

        // Owner release in the timeout cycle wins over the watchdog.
        ack = 1'b0;
        repeat (3) tick();
        req = 4'b1000; tick();
        check("rel_wins_gnt",  32'(gnt),  32'b1000);
        check("rel_wins_tout", 32'(tout), 32'h0);

        // Reset mid-grant, then re-arbitration on the first edge out of reset.
        req = 4'b0100; tick();
        check("pre_rst_gnt", 32'(gnt), 32'b0100);
        rst = 1'b1; tick();
        check("mid_rst_gnt",  32'(gnt),  32'h0);
        check("mid_rst_busy", 32'(busy), 32'h0);
        rst = 1'b0; tick();
        check("post_rst_gnt",  32'(gnt),  32'b0100);
        check("post_rst_busy", 32'(busy), 32'h1);

        // Random phase: slowly toggling requests, sparse ack, rare reset.
        rreq = req;
        for (int c = 0; c < 10000; c++) begin
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(7) == 0) rreq[b] = ~rreq[b];
            end
            req = rreq;
            ack = ($urandom_range(3) == 0);
            rst = ($urandom_range(499) == 0);
            tick();
        end
        rst = 1'b0; req = '0; ack = 1'b0;
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
